// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage feeding the processor core. Sequences an 8-bit PC,
//            fetches INST_W-bit words over a single-outstanding req/ack
//            memory handshake, buffers them in a DEPTH-entry FIFO and hands
//            {pc, word} pairs to decode over valid/ready. Supports redirect
//            (flush + new PC) and halt.
// Ports    : clk, rst_n (async, active low)
//            imem_req/imem_addr/imem_ack/imem_rdata  - instruction memory
//            inst_valid/inst_ready/inst_data/pc_counter - decode side
//            redirect_valid/redirect_target           - branch/jump taken
//            halt (in, level), halted (out)
//            perf_fetch_cnt/perf_flush_cnt            - only with macro below
// Options  : FETCH_PERF_CNT_EN adds saturating 16-bit counters of delivered
//            instructions and of redirects.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [7:0]        imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [7:0]        pc_counter,
  input  logic              redirect_valid,
  input  logic [7:0]        redirect_target,
  input  logic              halt,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        fetch_pc_q, fetch_pc_d;
  logic [7:0]        addr_q, addr_d;
  logic              discard_q, discard_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;

  logic [7:0]        buf_pc_q   [DEPTH];
  logic [INST_W-1:0] buf_data_q [DEPTH];

  logic              pop;
  logic              push;

  // --------------------------------------------------------------------------
  // Buffer bookkeeping
  // --------------------------------------------------------------------------
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  // A response is kept only if it was not invalidated by an earlier redirect
  // (discard_q) or by a redirect arriving in the same cycle as the ack.
  assign push       = (state_q == ST_REQ) && imem_ack && !discard_q && !redirect_valid;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // --------------------------------------------------------------------------
  // Fetch sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    discard_d  = discard_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
        end
        if (halt) begin
          state_d = ST_HALTED;
        end else if (count_q < DEPTH_CNT) begin
          state_d = ST_REQ;
          addr_d  = fetch_pc_d;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          discard_d = 1'b0;
          if (redirect_valid) begin
            fetch_pc_d = redirect_target;
          end else if (push) begin
            fetch_pc_d = fetch_pc_q + 8'd1;
          end
          // Back-to-back issue: count_d already accounts for this cycle's
          // push, pop and any flush, so a full buffer being drained still
          // keeps the request stream going.
          if (halt) begin
            state_d = ST_HALTED;
          end else if (count_d < DEPTH_CNT) begin
            state_d = ST_REQ;
            addr_d  = fetch_pc_d;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (redirect_valid) begin
          // Request must stay stable until acked; remember to drop its data.
          fetch_pc_d = redirect_target;
          discard_d  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
        end
        if (!halt) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      discard_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is reset so that pc_counter/inst_data read zero out of reset.
  // While a non-discarded request is outstanding fetch_pc_q equals its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_pc_q[i]   <= '0;
        buf_data_q[i] <= '0;
      end
    end else if (push) begin
      buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
      buf_data_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = addr_q;
  assign inst_data  = buf_data_q[rd_ptr_q];
  assign pc_counter = buf_pc_q[rd_ptr_q];
  assign halted     = (state_q == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters (saturating)
  // --------------------------------------------------------------------------
  logic [15:0] perf_fetch_q, perf_fetch_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_flush_d = perf_flush_q;
    if (pop && (perf_fetch_q != 16'hFFFF)) begin
      perf_fetch_d = perf_fetch_q + 16'd1;
    end
    if (redirect_valid && (perf_flush_q != 16'hFFFF)) begin
      perf_flush_d = perf_flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  // Counters not built: no extra ports or state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. A transaction-level
//            reference tracks the PC each delivered word must carry (sequential
//            order, restarting at each redirect target) and the word memory
//            returns for it; handshake rules are checked cycle by cycle.
//            Build with FETCH_PERF_CNT_EN to also check the counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam int unsigned INST_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req;
  logic [7:0]        imem_addr;
  logic              imem_ack = 1'b0;
  logic [INST_W-1:0] imem_rdata = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [INST_W-1:0] inst_data;
  logic [7:0]        pc_counter;
  logic              redirect_valid = 1'b0;
  logic [7:0]        redirect_target = 8'h00;
  logic              halt = 1'b0;
  logic              halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       perf_fetch_cnt;
  logic [15:0]       perf_flush_cnt;
`endif

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .INST_W   (INST_W)
  ) dut (
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
`endif
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .pc_counter      (pc_counter),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- stimulus knobs ----------------
  int         ready_mode = 0;   // 0 fixed value, 1 random, 2 ready until 10 delivered
  logic       ready_val  = 1'b1;
  int         ack_mode   = 0;   // 0 tied high, 1 fixed wait, 2 random wait 0..3
  int         fixed_wait = 0;
  int         data_mode  = 0;
  logic       halt_knob  = 1'b0;
  logic       rand_ctrl  = 1'b0;
  logic       redir_req  = 1'b0;
  logic [7:0] redir_tgt  = 8'h00;

  // ---------------- reference state ----------------
  logic [7:0]  exp_pc;
  int          n_deliv, n_redir;
  logic        req_wait_prev, hold_prev, redir_prev;
  logic [7:0]  prev_addr, prev_pc;
  logic [31:0] prev_data;
  logic        mem_busy;
  int          mem_wait;
  logic        ack_now, req_new_now;
  logic [7:0]  last_ack_addr, last_deliv_pc;
  int          halt_age, halt_low_age;
  logic [7:0]  deliv_log[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (data_mode == 0) return 32'hA000_0000 + {24'h0, a};
    return {~a, a, 8'hC3, a};
  endfunction

  task automatic model_clear();
    exp_pc        = RESET_PC;
    n_deliv       = 0;
    n_redir       = 0;
    req_wait_prev = 1'b0;
    hold_prev     = 1'b0;
    redir_prev    = 1'b0;
    mem_busy      = 1'b0;
    mem_wait      = 0;
    halt_age      = 0;
    halt_low_age  = 0;
    deliv_log.delete();
  endtask

  task automatic drive_inputs();
    if (ready_mode == 1)      inst_ready = ($urandom_range(0, 9) < 7);
    else if (ready_mode == 2) inst_ready = (n_deliv < 10);
    else                      inst_ready = ready_val;
    if (rand_ctrl) begin
      if ($urandom_range(0, 39) == 0) halt_knob = ~halt_knob;
      if ($urandom_range(0, 29) == 0) begin
        redir_req = 1'b1;
        redir_tgt = 8'($urandom_range(0, 255));
      end
    end
    halt            = halt_knob;
    redirect_valid  = redir_req;
    redirect_target = redir_tgt;
    redir_req       = 1'b0;
    if (ack_mode == 0) begin
      imem_ack = 1'b1;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (ack_mode == 1) ? fixed_wait : int'($urandom_range(0, 3));
      end
      if (mem_wait == 0) begin
        imem_ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        imem_ack = 1'b0;
        mem_wait--;
      end
    end else begin
      imem_ack = 1'b0;
    end
    imem_rdata = mem_word(imem_addr);
    ack_now    = imem_ack && imem_req;
    if (ack_now) last_ack_addr = imem_addr;
  endtask

  // Evaluates everything that will happen at the coming rising edge.
  task automatic model_check();
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetch", 32'(perf_fetch_cnt), 32'(n_deliv));
    check_eq("perf_flush", 32'(perf_flush_cnt), 32'(n_redir));
`endif
    if (req_wait_prev) begin
      check_eq("req_held", 32'(imem_req), 32'd1);
      check_eq("addr_held", 32'(imem_addr), 32'(prev_addr));
    end
    if (halted) check_eq("halted_noreq", 32'(imem_req), 32'd0);
    if (redir_prev) check_eq("flush_empty", 32'(inst_valid), 32'd0);
    if (hold_prev) begin
      check_eq("valid_hold", 32'(inst_valid), 32'd1);
      check_eq("pc_hold", 32'(pc_counter), 32'(prev_pc));
      check_eq("data_hold", inst_data, prev_data);
    end
    if (halt) begin halt_age++; halt_low_age = 0; end
    else      begin halt_low_age++; halt_age = 0; end
    if (halt_age >= 6)     check_eq("halt_takes", 32'(halted), 32'd1);
    if (halt_low_age >= 2) check_eq("halt_clears", 32'(halted), 32'd0);
    if (inst_valid && inst_ready) begin
      check_eq("pc_seq", 32'(pc_counter), 32'(exp_pc));
      check_eq("data", inst_data, mem_word(exp_pc));
      deliv_log.push_back(pc_counter);
      last_deliv_pc = pc_counter;
      exp_pc = exp_pc + 8'd1;
      n_deliv++;
    end
    if (redirect_valid) begin
      exp_pc = redirect_target;
      n_redir++;
    end
    req_new_now   = imem_req && !req_wait_prev;
    req_wait_prev = imem_req && !imem_ack;
    prev_addr     = imem_addr;
    hold_prev     = inst_valid && !inst_ready && !redirect_valid;
    redir_prev    = redirect_valid;
    prev_pc       = pc_counter;
    prev_data     = inst_data;
  endtask

  task automatic tick();
    @(negedge clk);
    drive_inputs();
    #1;
    model_check();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_data", inst_data, 32'd0);
    check_eq("rst_pc", 32'(pc_counter), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_perf_fetch", 32'(perf_fetch_cnt), 32'd0);
    check_eq("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif
    halt_knob      = 1'b0;
    redir_req      = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  initial begin
    int  k;
    bit  found;
    logic [7:0] acked;

    // ---- A: reset release, tied ack, free flow ----
    ack_mode = 0; ready_mode = 0; ready_val = 1'b1; data_mode = 0;
    apply_reset();
    tick();
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_addr", 32'(imem_addr), 32'(RESET_PC));
    tick();
    check_eq("first_valid", 32'(inst_valid), 32'd1);
    check_eq("first_pc", 32'(pc_counter), 32'(RESET_PC));
    check_eq("first_data", inst_data, 32'hA000_0000 + 32'(RESET_PC));
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("stream_valid", 32'(inst_valid), 32'd1);
    end

    // ---- B: decode stalls from reset, buffer fills, then resumes ----
    ready_val = 1'b0;
    apply_reset();
    repeat (6) tick();
    check_eq("full_req_drop", 32'(imem_req), 32'd0);
    check_eq("full_valid", 32'(inst_valid), 32'd1);
    check_eq("full_pc_hold", 32'(pc_counter), 32'(RESET_PC));
    ready_val = 1'b1;
    repeat (10) tick();
    check_eq("resume_progress", 32'(n_deliv >= 5), 32'd1);

    // ---- C: redirect while a slow request is pending ----
    ack_mode = 1; fixed_wait = 3;
    apply_reset();
    found = 0;
    for (k = 0; k < 200 && !found; k++) begin
      tick();
      if (req_new_now && imem_addr == 8'h05 && !ack_now) found = 1;
    end
    check_eq("c_reach_05", 32'(found), 32'd1);
    redir_req = 1'b1; redir_tgt = 8'h40;
    tick();
    check_eq("c_addr_stays", 32'(imem_addr), 32'h05);
    found = 0;
    for (k = 0; k < 20 && !found; k++) begin
      tick();
      if (ack_now) found = 1;
    end
    check_eq("c_ack_seen", 32'(found), 32'd1);
    tick();
    check_eq("c_new_req", 32'(imem_req), 32'd1);
    check_eq("c_new_addr", 32'(imem_addr), 32'h40);
    found = 0;
    for (k = 0; k < 20 && !found; k++) begin
      tick();
      if (inst_valid && inst_ready) begin
        found = 1;
        check_eq("c_first_pc", 32'(pc_counter), 32'h40);
      end
    end
    check_eq("c_delivery", 32'(found), 32'd1);

    // ---- D: PC wrap after redirect to 8'hFE ----
    ack_mode = 0;
    redir_req = 1'b1; redir_tgt = 8'hFE;
    tick();
    deliv_log.delete();
    repeat (8) tick();
    check_eq("wrap_count", 32'(deliv_log.size() >= 4), 32'd1);
    if (deliv_log.size() >= 4) begin
      check_eq("wrap_0", 32'(deliv_log[0]), 32'hFE);
      check_eq("wrap_1", 32'(deliv_log[1]), 32'hFF);
      check_eq("wrap_2", 32'(deliv_log[2]), 32'h00);
      check_eq("wrap_3", 32'(deliv_log[3]), 32'h01);
    end

    // ---- E: halt during an outstanding request ----
    ack_mode = 1; fixed_wait = 2;
    found = 0;
    for (k = 0; k < 50 && !found; k++) begin
      tick();
      if (req_new_now && !ack_now) found = 1;
    end
    check_eq("e_req_seen", 32'(found), 32'd1);
    halt_knob = 1'b1;
    found = 0;
    for (k = 0; k < 10 && !found; k++) begin
      tick();
      if (ack_now) found = 1;
    end
    check_eq("e_ack_seen", 32'(found), 32'd1);
    acked = last_ack_addr;
    tick();
    check_eq("e_halted", 32'(halted), 32'd1);
    check_eq("e_no_req", 32'(imem_req), 32'd0);
    repeat (5) begin
      tick();
      check_eq("e_stay_halted", 32'(halted), 32'd1);
    end
    check_eq("e_pending_delivered", 32'(last_deliv_pc), 32'(acked));
    halt_knob = 1'b0;
    found = 0;
    for (k = 0; k < 10 && !found; k++) begin
      tick();
      if (imem_req) found = 1;
    end
    check_eq("e_resume_req", 32'(found), 32'd1);
    check_eq("e_resume_addr", 32'(imem_addr), 32'(acked + 8'd1));

    // ---- F: randomized traffic (reset lands mid-run) ----
    data_mode = 1; ack_mode = 2; ready_mode = 1;
    apply_reset();
    rand_ctrl = 1'b1;
    repeat (2000) tick();
    rand_ctrl = 1'b0;
    check_eq("rand_progress", 32'(n_deliv >= 100), 32'd1);

`ifdef FETCH_PERF_CNT_EN
    // ---- G: counters: 10 deliveries, 2 redirects, then async reset ----
    data_mode = 0; ack_mode = 0; ready_mode = 2;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin redir_req = 1'b1; redir_tgt = 8'h20; end
      if (i == 6) begin redir_req = 1'b1; redir_tgt = 8'h30; end
      tick();
    end
    check_eq("perf_fetch_10", 32'(perf_fetch_cnt), 32'd10);
    check_eq("perf_flush_2", 32'(perf_flush_cnt), 32'd2);
    ready_mode = 0; ready_val = 1'b1;
    repeat (5) tick();
    apply_reset();
`else
    apply_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the Processor core. Replaces the free-running bench counter that drives pc_counter: it sequences an 8-bit program counter and fetches 32-bit words from instruction memory over a req/ack handshake. Fetched words are buffered in a small FIFO and delivered to decode over a valid/ready interface, together with each word's PC. Supports redirect (branch/jump) with flush, and halt.

Parameters:
DEPTH, 2, fetch buffer entries (power of two, >=2)
RESET_PC, 8'h00, PC loaded on reset
INST_W, 32, instruction width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  8  fetch address, stable while imem_req high
imem_ack  in  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  in  INST_W  returned instruction word
inst_valid  out  1  buffer head valid
inst_ready  in  1  decode accepts head
inst_data  out  INST_W  head instruction
pc_counter  out  8  PC of head instruction
redirect_valid  in  1  branch/jump taken, one-cycle pulse
redirect_target  in  8  new PC
halt  in  1  level; stop issuing new fetches
halted  out  1  halt in effect and no request outstanding

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, pc_counter=0, halted=0, discard flag=0. First imem_req rises the first clock edge after rst_n deasserts.
- FSM states: IDLE, REQ, HALTED.
  - IDLE: if !halt and (count + 0) < DEPTH -> drive imem_req=1, imem_addr=fetch_pc, go REQ. If halt -> HALTED.
  - REQ: hold req/addr. On imem_ack: if discard=0, push {fetch_pc, imem_rdata}, fetch_pc<=fetch_pc+1; clear discard; next state IDLE (back-to-back: if space remains after this cycle's push/pop and !halt, stay in REQ with new addr, giving 1 fetch/cycle with zero-wait memory).
  - HALTED: imem_req=0, halted=1; leave to IDLE when halt=0.
- At most one outstanding request. Buffer-full check counts a same-cycle pop (push+pop when full allowed).
- Latency: zero-wait memory -> instruction at address A visible on inst_valid the cycle after ack.
- Head transfer when inst_valid && inst_ready; pc_counter/inst_data hold while valid && !ready.
- Redirect (highest priority): flush buffer same edge (inst_valid=0 next cycle), fetch_pc<=redirect_target. If in REQ without ack this cycle: keep req/addr stable, set discard=1; response dropped on ack; new fetch from target follows. If ack coincides with redirect: response dropped, next request to target.
- Redirect while halted: fetch_pc updated, no request until halt drops.
- halt during REQ: outstanding completes and pushes normally; then HALTED. halted asserts only when no request outstanding. Buffer continues draining while halted.
- PC arithmetic modulo 256: 8'hFF+1 -> 8'h00, no flag.
- Async reset mid-request drops request immediately; memory must tolerate abandoned request.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds output perf_fetch_cnt[15:0] (instructions delivered to decode, saturating at 16'hFFFF) and perf_flush_cnt[15:0] (redirects taking effect, saturating); both reset to 0. When undefined, ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, imem_ack tied 1, imem_rdata=32'hA000_0000+addr, inst_ready=1 -> imem_addr 0,1,2...; pc_counter 0,1,2 with inst_data 32'hA000_0000,..01,..02 one per cycle after 2-cycle startup.
- inst_ready=0 for 5 cycles -> buffer fills at DEPTH=2, imem_req drops, pc_counter holds 0; release -> sequence resumes 0,1,2 with no gaps or duplicates.
- Redirect to 8'h40 while request to 8'h05 awaits ack (ack delayed 3 cycles) -> imem_addr stays 8'h05 until ack, word discarded, next imem_addr=8'h40, next delivered pc_counter=8'h40.
- Start at RESET_PC=8'hFE, free flow -> pc_counter FE, FF, 00, 01.
- halt=1 mid-request -> pending word delivered, halted=1 next cycle after ack, no imem_req; halt=0 -> fetch resumes at next sequential PC.
- With FETCH_PERF_CNT_EN: 10 delivered instructions and 2 redirects -> perf_fetch_cnt=10, perf_flush_cnt=2; async reset mid-run -> both 0.
